// File: rtl/req_mon_pkg.sv
// Shared types for the request hold monitor: per-channel FSM states and
// the failure cause encoding reported on fail_code.
package req_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HOLD   = 2'b01,
        ST_WINDOW = 2'b10
    } chan_state_e;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_SHORT = 2'b01,
        FC_LONG  = 2'b10
    } fail_code_e;

endpackage

// File: rtl/req_mon_chan.sv
// One monitored request channel: measures a consecutive hold (mode 0) or a
// high-cycle count inside a window (mode 1) against latched min/max limits.
module req_mon_chan
    import req_mon_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              mode,
    input  logic [CNT_W-1:0]  min_len,
    input  logic [CNT_W-1:0]  max_len,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              clr,
    output logic              pass_o,
    output logic              fail_o,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  len_o,
    output logic              err_sticky,
    output logic [PASS_W-1:0] pass_cnt
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};
    localparam logic [PASS_W-1:0] PASS_ONE  = {{(PASS_W-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] PASS_MAX  = {PASS_W{1'b1}};

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            cnt_inc = CNT_MAX;
        end else begin
            cnt_inc = v + CNT_ONE;
        end
    endfunction

    chan_state_e        state_r, state_nx_s;
    logic               req_q_r;
    logic               block_r;
    logic [CNT_W-1:0]   min_r, max_r, win_r, cnt_r, tmr_r;
    logic [CNT_W-1:0]   min_nx_s, max_nx_s, win_nx_s, cnt_nx_s, tmr_nx_s;
    logic [CNT_W-1:0]   cnt_inc_s, tmr_inc_s, eval_s;
    logic               rise_s, done_s, pass_s, fail_s;
    fail_code_e         code_s;
    logic [PASS_W-1:0]  pcnt_base_s, pcnt_nx_s;

    // block_r suppresses a req that is already high when reset releases.
    assign rise_s = req & ~req_q_r & ~block_r;

    // Next-state, latched configuration and counter updates.
    always_comb begin
        state_nx_s = state_r;
        min_nx_s   = min_r;
        max_nx_s   = max_r;
        win_nx_s   = win_r;
        cnt_nx_s   = cnt_r;
        tmr_nx_s   = tmr_r;
        done_s     = 1'b0;
        eval_s     = cnt_r;
        cnt_inc_s  = cnt_inc(cnt_r);
        tmr_inc_s  = cnt_inc(tmr_r);
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    min_nx_s = (min_len == CNT_ZERO) ? CNT_ONE : min_len;
                    max_nx_s = max_len;
                    win_nx_s = (win_len == CNT_ZERO) ? CNT_ONE : win_len;
                    cnt_nx_s = CNT_ONE;
                    tmr_nx_s = CNT_ONE;
                    if (mode == 1'b0) begin
                        state_nx_s = ST_HOLD;
                    end else if (win_nx_s == CNT_ONE) begin
                        // a one-cycle window is already complete on the rise
                        done_s = 1'b1;
                        eval_s = CNT_ONE;
                    end else begin
                        state_nx_s = ST_WINDOW;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (req) begin
                    if (cnt_inc_s > max_r) begin
                        done_s     = 1'b1;
                        eval_s     = cnt_inc_s;
                        state_nx_s = ST_IDLE;
                    end else begin
                        cnt_nx_s = cnt_inc_s;
                    end
                end else begin
                    done_s     = 1'b1;
                    eval_s     = cnt_r;
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WINDOW: begin
                tmr_nx_s = tmr_inc_s;
                cnt_nx_s = req ? cnt_inc_s : cnt_r;
                if (tmr_inc_s >= win_r) begin
                    done_s     = 1'b1;
                    eval_s     = cnt_nx_s;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WINDOW;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Verdict on the measured count; min>max naturally fails every check.
    always_comb begin
        pass_s = 1'b0;
        fail_s = 1'b0;
        code_s = FC_NONE;
        if (done_s) begin
            if (eval_s < min_nx_s) begin
                fail_s = 1'b1;
                code_s = FC_SHORT;
            end else if (eval_s > max_nx_s) begin
                fail_s = 1'b1;
                code_s = FC_LONG;
            end else begin
                pass_s = 1'b1;
            end
        end else begin
            pass_s = 1'b0;
            fail_s = 1'b0;
        end
    end

    // Saturating pass counter; clr restarts it but a coincident pass still counts.
    always_comb begin
        pcnt_base_s = clr ? PASS_ZERO : pass_cnt;
        if (pass_s && (pcnt_base_s != PASS_MAX)) begin
            pcnt_nx_s = pcnt_base_s + PASS_ONE;
        end else begin
            pcnt_nx_s = pcnt_base_s;
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            req_q_r    <= 1'b0;
            block_r    <= 1'b1;
            min_r      <= CNT_ZERO;
            max_r      <= CNT_ZERO;
            win_r      <= CNT_ZERO;
            cnt_r      <= CNT_ZERO;
            tmr_r      <= CNT_ZERO;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            fail_code  <= FC_NONE;
            len_o      <= CNT_ZERO;
            err_sticky <= 1'b0;
            pass_cnt   <= PASS_ZERO;
        end else begin
            state_r    <= state_nx_s;
            req_q_r    <= req;
            block_r    <= block_r & req;
            min_r      <= min_nx_s;
            max_r      <= max_nx_s;
            win_r      <= win_nx_s;
            cnt_r      <= cnt_nx_s;
            tmr_r      <= tmr_nx_s;
            pass_o     <= pass_s;
            fail_o     <= fail_s;
            len_o      <= done_s ? eval_s : CNT_ZERO;
            err_sticky <= fail_s | (err_sticky & ~clr);
            if (fail_s) begin
                fail_code <= code_s;
            end else if (clr) begin
                fail_code <= FC_NONE;
            end else begin
                fail_code <= fail_code;
            end
            pass_cnt   <= pcnt_nx_s;
        end
    end

endmodule

// File: rtl/req_hold_monitor.sv
// Request hold monitor: NUM_CH independent channels, each checking how long
// (or how often) its request line stays high against per-channel limits.
module req_hold_monitor
    import req_mon_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 4,
    parameter int PASS_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        mode,
    input  logic [NUM_CH*CNT_W-1:0]  min_len,
    input  logic [NUM_CH*CNT_W-1:0]  max_len,
    input  logic [NUM_CH*CNT_W-1:0]  win_len,
    input  logic                     clr,
    output logic [NUM_CH-1:0]        pass_o,
    output logic [NUM_CH-1:0]        fail_o,
    output logic [NUM_CH*2-1:0]      fail_code,
    output logic [NUM_CH*CNT_W-1:0]  len_o,
    output logic [NUM_CH-1:0]        err_sticky,
    output logic [NUM_CH*PASS_W-1:0] pass_cnt
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_mon_chan #(
            .CNT_W  (CNT_W),
            .PASS_W (PASS_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .req        (req[g]),
            .mode       (mode[g]),
            .min_len    (min_len[g*CNT_W +: CNT_W]),
            .max_len    (max_len[g*CNT_W +: CNT_W]),
            .win_len    (win_len[g*CNT_W +: CNT_W]),
            .clr        (clr),
            .pass_o     (pass_o[g]),
            .fail_o     (fail_o[g]),
            .fail_code  (fail_code[g*2 +: 2]),
            .len_o      (len_o[g*CNT_W +: CNT_W]),
            .err_sticky (err_sticky[g]),
            .pass_cnt   (pass_cnt[g*PASS_W +: PASS_W])
        );
    end

endmodule

// File: tb/tb_req_hold_monitor.sv
// Directed and randomized bench for req_hold_monitor, checked every cycle
// against a count-based reference model of each channel's checks.
module tb_req_hold_monitor;

    localparam int NCH  = 4;
    localparam int CW   = 4;
    localparam int PW   = 2;
    localparam int CMAX = 15;
    localparam int PMAX = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req, mode;
    logic [NCH*CW-1:0] min_len, max_len, win_len;
    logic              clr;
    logic [NCH-1:0]    pass_o, fail_o, err_sticky;
    logic [NCH*2-1:0]  fail_code;
    logic [NCH*CW-1:0] len_o;
    logic [NCH*PW-1:0] pass_cnt;

    always #5 clk = ~clk;

    req_hold_monitor #(.NUM_CH(NCH), .CNT_W(CW), .PASS_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .min_len(min_len), .max_len(max_len), .win_len(win_len), .clr(clr),
        .pass_o(pass_o), .fail_o(fail_o), .fail_code(fail_code), .len_o(len_o),
        .err_sticky(err_sticky), .pass_cnt(pass_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model: kind of active check (0 none, 1 hold, 2 window), samples seen, highs seen
    int m_act[NCH], m_samp[NCH], m_high[NCH], m_min[NCH], m_max[NCH], m_win[NCH];
    int m_prev[NCH], m_blk[NCH];
    int e_pass[NCH], e_fail[NCH], e_code[NCH], e_len[NCH], e_stk[NCH], e_pcnt[NCH];

    function automatic int sat(int v, int top);
        return (v > top) ? top : v;
    endfunction

    task automatic chk(string tag, int ch, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s ch%0d: observed %0d expected %0d", tag, ch, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int r, dec, val, j;
            r = int'(req[c]);
            if (!rst_n) begin
                m_act[c] = 0; m_prev[c] = 0; m_blk[c] = 1;
                e_pass[c] = 0; e_fail[c] = 0; e_code[c] = 0;
                e_len[c] = 0; e_stk[c] = 0; e_pcnt[c] = 0;
                continue;
            end
            dec = 0;
            val = 0;
            if (m_act[c] == 0) begin
                if (r == 1 && m_prev[c] == 0 && m_blk[c] == 0) begin
                    m_min[c]  = (min_len[c*CW +: CW] == 4'd0) ? 1 : int'(min_len[c*CW +: CW]);
                    m_max[c]  = int'(max_len[c*CW +: CW]);
                    m_win[c]  = (win_len[c*CW +: CW] == 4'd0) ? 1 : int'(win_len[c*CW +: CW]);
                    m_samp[c] = 1;
                    m_high[c] = 1;
                    if (mode[c] == 1'b0) m_act[c] = 1;
                    else if (m_win[c] == 1) begin dec = 1; val = 1; end
                    else m_act[c] = 2;
                end
            end else if (m_act[c] == 1) begin
                if (r == 1) begin
                    if (sat(m_high[c] + 1, CMAX) > m_max[c]) begin
                        dec = 1; val = sat(m_high[c] + 1, CMAX); m_act[c] = 0;
                    end else begin
                        m_high[c]++;
                    end
                end else begin
                    dec = 1; val = sat(m_high[c], CMAX); m_act[c] = 0;
                end
            end else begin
                m_samp[c]++;
                m_high[c] += r;
                if (sat(m_samp[c], CMAX) >= m_win[c]) begin
                    dec = 1; val = sat(m_high[c], CMAX); m_act[c] = 0;
                end
            end
            j = (dec == 0) ? 0 : (val < m_min[c]) ? 1 : (val > m_max[c]) ? 2 : 0;
            e_pass[c] = (dec == 1 && j == 0) ? 1 : 0;
            e_fail[c] = (dec == 1 && j != 0) ? 1 : 0;
            e_len[c]  = (dec == 1) ? val : 0;
            e_stk[c]  = (e_fail[c] == 1 || (e_stk[c] == 1 && !clr)) ? 1 : 0;
            e_code[c] = (e_fail[c] == 1) ? j : (clr ? 0 : e_code[c]);
            e_pcnt[c] = sat((clr ? 0 : e_pcnt[c]) + e_pass[c], PMAX);
            m_prev[c] = r;
            m_blk[c]  = (m_blk[c] == 1 && r == 1) ? 1 : 0;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            chk("pass_o",     c, pass_o[c],              e_pass[c]);
            chk("fail_o",     c, fail_o[c],              e_fail[c]);
            chk("fail_code",  c, fail_code[c*2 +: 2],    e_code[c]);
            chk("len_o",      c, len_o[c*CW +: CW],      e_len[c]);
            chk("err_sticky", c, err_sticky[c],          e_stk[c]);
            chk("pass_cnt",   c, pass_cnt[c*PW +: PW],   e_pcnt[c]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_cfg(int c, int md, int mn, int mx, int wn);
        mode[c]              = md[0];
        min_len[c*CW +: CW]  = mn[CW-1:0];
        max_len[c*CW +: CW]  = mx[CW-1:0];
        win_len[c*CW +: CW]  = wn[CW-1:0];
    endtask

    task automatic drive_bits(int c, logic [15:0] pat, int n);
        for (int i = n - 1; i >= 0; i--) begin
            req[c] = pat[i];
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mode = '0; clr = 1'b0;
        min_len = '0; max_len = '0; win_len = '0;
        tick();
        tick();
        for (int c = 0; c < NCH; c++) begin
            chk("rst_pass_cnt", c, pass_cnt[c*PW +: PW], 0);
            chk("rst_sticky",   c, err_sticky[c], 0);
        end
        rst_n = 1'b1;
        tick();

        // mode 0, min=max=2, two high cycles
        set_cfg(0, 0, 2, 2, 0);
        drive_bits(0, 16'b110, 3);
        chk("r38_pass", 0, pass_o[0], 1);
        chk("r38_len",  0, len_o[3:0], 2);
        chk("r38_pcnt", 0, pass_cnt[1:0], 1);
        tick();

        // mode 0, min=3 max=5: seven highs fail long on the 6th, two highs fail short
        set_cfg(0, 0, 3, 5, 0);
        drive_bits(0, 16'b111111, 6);
        chk("r39_fail", 0, fail_o[0], 1);
        chk("r39_code", 0, fail_code[1:0], 2);
        chk("r39_len",  0, len_o[3:0], 6);
        drive_bits(0, 16'b10, 2);
        chk("r39_nofail", 0, fail_o[0], 0);
        drive_bits(0, 16'b110, 3);
        chk("r39_short", 0, fail_code[1:0], 1);
        tick();

        // mode 1, win=6, min=3, max=4
        set_cfg(0, 1, 3, 4, 6);
        drive_bits(0, 16'b101010, 6);
        chk("r40_pass", 0, pass_o[0], 1);
        chk("r40_len",  0, len_o[3:0], 3);
        drive_bits(0, 16'b111110, 6);
        chk("r40_long", 0, fail_code[1:0], 2);
        tick();

        // zero window and zero min both behave as 1
        set_cfg(0, 1, 0, 1, 0);
        drive_bits(0, 16'b1, 1);
        chk("win0_pass", 0, pass_o[0], 1);
        chk("win0_len",  0, len_o[3:0], 1);
        drive_bits(0, 16'b0, 1);

        // clr coincident with a failing decision, then clr alone
        set_cfg(0, 0, 3, 5, 0);
        req[0] = 1'b1; tick(); tick();
        req[0] = 1'b0; clr = 1'b1; tick();
        chk("r42_fail",   0, fail_o[0], 1);
        chk("r42_sticky", 0, err_sticky[0], 1);
        clr = 1'b0; tick();
        clr = 1'b1; tick();
        chk("r42_clr_sticky", 0, err_sticky[0], 0);
        chk("r42_clr_pcnt",   0, pass_cnt[1:0], 0);
        clr = 1'b0; tick();

        // reset in the second hold cycle, req held across release
        set_cfg(0, 0, 2, 5, 0);
        drive_bits(0, 16'b11, 2);
        rst_n = 1'b0; tick();
        for (int c = 0; c < NCH; c++) chk("r41_rst_out", c, {pass_o[c], fail_o[c], len_o[c*CW +: CW]}, 0);
        rst_n = 1'b1;
        drive_bits(0, 16'b110, 3);
        chk("r41_nocheck", 0, {pass_o[0], fail_o[0]}, 0);
        drive_bits(0, 16'b110, 3);
        chk("r41_restart", 0, pass_o[0], 1);
        clr = 1'b1; tick(); clr = 1'b0;

        // four passes saturate the 2-bit pass counter of channel 0 only
        set_cfg(0, 0, 1, 2, 0);
        for (int k = 0; k < 4; k++) drive_bits(0, 16'b100, 3);
        chk("r43_sat", 0, pass_cnt[1:0], 3);
        for (int c = 1; c < NCH; c++) chk("r43_other", c, pass_cnt[c*PW +: PW], 0);

        // randomized traffic, configuration churn, clr and occasional reset
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 19) == 0)
                    set_cfg(c, $urandom_range(0, 1), $urandom_range(0, 7),
                            $urandom_range(0, 15), $urandom_range(0, 12));
                if ($urandom_range(0, 99) < (c == 3 ? 5 : 35)) req[c] = ~req[c];
            end
            clr   = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/req_hold_monitor.md
REQ_HOLD_MONITOR -- requirements
Module: req_hold_monitor

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent request channels monitored.
REQ-002 Parameter CNT_W, default 4: width of every length, window and config counter.
REQ-003 Parameter PASS_W, default 8: width of each per-channel pass counter.
REQ-004 clk  input  1  single clock; all sampling on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NUM_CH  monitored request lines, one bit per channel.
REQ-007 mode  input  NUM_CH  per channel: 0 = consecutive hold check, 1 = non-consecutive count-in-window check.
REQ-008 min_len  input  NUM_CH*CNT_W  per-channel minimum high-cycle count.
REQ-009 max_len  input  NUM_CH*CNT_W  per-channel maximum high-cycle count.
REQ-010 win_len  input  NUM_CH*CNT_W  per-channel window length in cycles (mode 1 only).
REQ-011 clr  input  1  synchronous clear of sticky status and pass counters.
REQ-012 pass_o  output  NUM_CH  one-cycle pulse: check passed.
REQ-013 fail_o  output  NUM_CH  one-cycle pulse: check failed.
REQ-014 fail_code  output  NUM_CH*2  cause of last failure: 01 short, 10 long, 00 none.
REQ-015 len_o  output  NUM_CH*CNT_W  measured high-cycle count, valid while pass_o or fail_o is high.
REQ-016 err_sticky  output  NUM_CH  set on any fail_o, held until clr or reset.
REQ-017 pass_cnt  output  NUM_CH*PASS_W  saturating count of pass_o pulses.

Function
REQ-018 Each channel SHALL run a FSM with states IDLE, HOLD (mode 0) and WINDOW (mode 1).
REQ-019 Rise detect SHALL be req & ~req_q, where req_q is req registered one cycle.
REQ-020 On rise in IDLE: latch mode, min_len, max_len, win_len; set count=1; go HOLD or WINDOW; later config changes SHALL NOT affect the active check.
REQ-021 HOLD: each cycle req high increments count; if count would exceed max, SHALL assert fail_o with code 10 in that cycle and go to IDLE.
REQ-022 HOLD: first cycle req low SHALL assert pass_o if min<=count<=max, otherwise fail_o with code 01, then go to IDLE.
REQ-023 WINDOW: a window timer starts at 1 on rise; count increments on every cycle req high; a new rise inside the window SHALL be ignored.
REQ-024 WINDOW: in the cycle the timer reaches win_len, SHALL evaluate count: pass if min<=count<=max, code 01 if below min, code 10 if above max; then go to IDLE.
REQ-025 Latency: pass_o or fail_o SHALL be registered and appear the cycle after the deciding sample.
REQ-026 A rise in the same cycle a check completes SHALL NOT start a new check; the earliest restart is the next rise.
REQ-027 Latched min_len=0 SHALL be treated as 1; latched win_len=0 SHALL be treated as 1.
REQ-028 Latched min>max SHALL make every check of that channel fail: code 01 if count<min, else code 10.
REQ-029 count and the window timer SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 pass_cnt SHALL saturate at 2^PASS_W-1.
REQ-031 clr SHALL clear err_sticky, fail_code and pass_cnt; it SHALL NOT abort an in-progress check.
REQ-032 If clr and a new fail_o occur in the same cycle, fail SHALL win: err_sticky set, fail_code updated.
REQ-033 Channels SHALL be fully independent; they share no state.

Reset
REQ-034 While rst_n is low at a clock edge, every FSM SHALL go to IDLE, req_q SHALL be 0, and all outputs SHALL be 0.
REQ-035 Reset mid-check SHALL abort the check with no pass_o or fail_o; a req already high at release SHALL NOT count as a rise.

Structure
REQ-036 Package req_mon_pkg SHALL hold the FSM state enum, the fail_code enum and the constants FC_NONE, FC_SHORT and FC_LONG.
REQ-037 Sub-module req_mon_chan SHALL implement one channel and SHALL be instantiated NUM_CH times by a generate loop.

Verification
REQ-038 Mode 0, min=2, max=2, req high 2 cycles -> pass_o, len_o=2, pass_cnt=1.
REQ-039 Mode 0, min=3, max=5, req high 7 cycles -> fail_o, code 10, len_o=6, pulse on the 6th-high-cycle decision; req high 2 cycles -> code 01.
REQ-040 Mode 1, win=6, min=3, max=4, req pattern 1,0,1,0,1,0 -> pass_o after window, len_o=3; pattern 1,1,1,1,1,0 -> code 10.
REQ-041 Reset asserted in HOLD cycle 2 -> no pass/fail, outputs 0; req held high over release -> no new check until req drops and rises.
REQ-042 clr in the same cycle as fail_o -> err_sticky=1 next cycle; clr alone -> err_sticky=0, pass_cnt=0.
REQ-043 NUM_CH=4, PASS_W=2, four passes on channel 0 -> pass_cnt[0]=3 (saturated), channels 1-3 unaffected.
